// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller and result checker for the single-cycle CPU.
// Holds the CPU in reset, counts RUN cycles, detects halt as a PC self-loop,
// flags timeout, and compares NUM_SIG signals against expected values.
// Optional PC history buffer is enabled by defining RUN_MONITOR_PC_HISTORY_EN.
module cpu_run_monitor #(
    parameter int XLEN           = 32,
    parameter int NUM_SIG        = 1,
    parameter int RESET_CYCLES   = 3,
    parameter int HALT_STABLE    = 4,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int HIST_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          restart,
    input  logic [XLEN-1:0]               pc,
    input  logic [NUM_SIG*XLEN-1:0]       sig,
    input  logic [NUM_SIG*XLEN-1:0]       sig_exp,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic                          cpu_reset,
    output logic                          running,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [31:0]                   cycle_count,
    output logic [XLEN-1:0]               halt_pc,
    output logic [NUM_SIG-1:0]            mismatch,
    output logic [XLEN-1:0]               hist_pc
);
    localparam int          HCW    = $clog2(RESET_CYCLES + 1);
    localparam int          SCW    = $clog2(HALT_STABLE + 1);
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALT, S_TOUT} state_t;

    state_t             r_state, w_state_nxt;
    logic [HCW-1:0]     r_hold_cnt;
    logic [XLEN-1:0]    r_prev_pc;
    logic [SCW-1:0]     r_stable, w_stable_nxt;
    logic               r_first;
    logic [31:0]        w_cc_inc;
    logic               w_pc_eq, w_hold_done, w_halt, w_tout;
    logic [NUM_SIG-1:0] w_mis;

    // Per-channel compare of checked signal against its expected value
    for (genvar gi = 0; gi < NUM_SIG; gi++) begin : g_cmp
        assign w_mis[gi] = sig[gi*XLEN +: XLEN] != sig_exp[gi*XLEN +: XLEN];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_HOLD;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic and halt/timeout decision; halt wins over timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_cc_inc     = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
        w_pc_eq      = (pc == r_prev_pc);
        w_stable_nxt = (r_first || !w_pc_eq) ? '0 : r_stable + SCW'(1);
        w_hold_done  = (r_hold_cnt == HCW'(RESET_CYCLES - 1));
        w_halt       = 1'b0;
        w_tout       = 1'b0;
        if (r_state == S_RUN) begin
            w_halt = !r_first && w_pc_eq && (r_stable == SCW'(HALT_STABLE - 1));
            w_tout = !w_halt && (w_cc_inc == TO_LIM);
        end
        if (restart) begin
            w_state_nxt = S_HOLD;
        end else begin
            case (r_state)
                S_HOLD:  if (w_hold_done) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_halt)      w_state_nxt = S_HALT;
                    else if (w_tout) w_state_nxt = S_TOUT;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs, hold counter and PC-stability tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
            mismatch    <= '0;
            r_hold_cnt  <= '0;
            r_prev_pc   <= '0;
            r_stable    <= '0;
            r_first     <= 1'b0;
        end else if (restart) begin
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
            mismatch    <= '0;
            r_hold_cnt  <= '0;
            r_prev_pc   <= '0;
            r_stable    <= '0;
            r_first     <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_hold_done) begin
                        cpu_reset  <= 1'b0;
                        running    <= 1'b1;
                        r_first    <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HCW'(1);
                    end
                end
                S_RUN: begin
                    cycle_count <= w_cc_inc;
                    r_prev_pc   <= pc;
                    r_stable    <= w_stable_nxt;
                    r_first     <= 1'b0;
                    if (w_halt || w_tout) begin
                        running  <= 1'b0;
                        done     <= 1'b1;
                        halt_pc  <= pc;
                        mismatch <= w_mis;
                        pass     <= w_halt && (w_mis == '0);
                        timeout  <= w_tout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RUN_MONITOR_PC_HISTORY_EN
    localparam int HW = $clog2(HIST_DEPTH);

    logic [XLEN-1:0] r_hist [HIST_DEPTH];
    logic [HW-1:0]   r_wptr;
    logic [HW-1:0]   w_rd_idx;

    // Circular PC history; records each new PC seen in RUN, survives restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
            r_wptr <= '0;
        end else if (!restart && r_state == S_RUN && (r_first || !w_pc_eq)) begin
            r_hist[r_wptr] <= pc;
            r_wptr         <= r_wptr + HW'(1);
        end
    end

    assign w_rd_idx = r_wptr - HW'(1) - hist_idx;
    assign hist_pc  = r_hist[w_rd_idx];
`else
    logic w_unused_hist;
    assign w_unused_hist = ^hist_idx;
    assign hist_pc       = '0;
`endif

endmodule
